// File: rtl/fsgnj_if.sv
// Operand/result bundle for the fsgnj sign-injection unit.
// The master drives operands; the slave (fsgnj) returns the registered result.
// With FSGNJ_EXT_OPS_EN defined the 2-bit op selector is carried as well.
interface fsgnj_if #(
   parameter int BUS_WIDTH = 64
);
   logic                 in_valid;
   logic [BUS_WIDTH-1:0] in1;
   logic [BUS_WIDTH-1:0] in2;
`ifdef FSGNJ_EXT_OPS_EN
   logic [1:0]           op;
`endif
   logic [BUS_WIDTH-1:0] out;
   logic                 out_valid;

   modport master (
`ifdef FSGNJ_EXT_OPS_EN
      output op,
`endif
      output in_valid, in1, in2,
      input  out, out_valid
   );

   modport slave (
`ifdef FSGNJ_EXT_OPS_EN
      input  op,
`endif
      input  in_valid, in1, in2,
      output out, out_valid
   );
endinterface

// File: rtl/fsgnj.sv
// FPU sign-injection unit (FSGNJ family), binary32 or binary64, one register stage.
// Result takes in1 without its sign plus a sign chosen from in2; if in2 is any NaN
// (quiet or signaling) in1 passes through bit-exact. No exception flags.
// Optional feature macro: FSGNJ_EXT_OPS_EN adds the op port (SGNJ/SGNJN/SGNJX).
// Without it the unit is SGNJ only.
module fsgnj #(
   parameter int BUS_WIDTH = 64
) (
   input  logic   clk,
   input  logic   rst,
   fsgnj_if.slave bus
);
   localparam int EXP_W  = (BUS_WIDTH == 32) ? 8 : 11;
   localparam int FRAC_W = BUS_WIDTH - 1 - EXP_W;

   generate
      if (BUS_WIDTH != 32 && BUS_WIDTH != 64) begin : g_bad_width
         $error("fsgnj: BUS_WIDTH must be 32 or 64");
      end
   endgenerate

   logic [EXP_W-1:0]     w_in2_exp;
   logic [FRAC_W-1:0]    w_in2_frac;
   logic                 w_in2_nan;
   logic                 w_in1_sign;
   logic                 w_in2_sign;
   logic                 w_sign;
   logic [BUS_WIDTH-1:0] w_result;
   logic [BUS_WIDTH-1:0] r_out;
   logic                 r_out_valid;

   assign w_in2_exp  = bus.in2[BUS_WIDTH-2 -: EXP_W];
   assign w_in2_frac = bus.in2[FRAC_W-1:0];
   assign w_in2_nan  = (&w_in2_exp) && (|w_in2_frac);
   assign w_in1_sign = bus.in1[BUS_WIDTH-1];
   assign w_in2_sign = bus.in2[BUS_WIDTH-1];

   // Select the injected sign; op encoding 11 behaves as plain SGNJ.
   always_comb begin
      w_sign = w_in2_sign;
`ifdef FSGNJ_EXT_OPS_EN
      case (bus.op)
         2'b01:   w_sign = ~w_in2_sign;
         2'b10:   w_sign = w_in1_sign ^ w_in2_sign;
         default: w_sign = w_in2_sign;
      endcase
`else
      // in1 sign only matters for SGNJX; keep it referenced so the plain
      // build has the same observable datapath shape.
      if (1'b0 && w_in1_sign) w_sign = w_in2_sign;
`endif
   end

   // NaN in in2 bypasses injection for every op.
   always_comb begin
      w_result = {w_sign, bus.in1[BUS_WIDTH-2:0]};
      if (w_in2_nan) begin
         w_result = bus.in1;
      end
   end

   // Result register: reset wins, otherwise capture on in_valid and hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out <= w_result;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_fsgnj.sv
// Self-checking bench for fsgnj: a 64-bit and a 32-bit instance, directed vectors
// plus a few random ones, expected results queued at drive time and checked one
// cycle later.
module tb_fsgnj;
   logic clk;
   logic rst;

   fsgnj_if #(.BUS_WIDTH(64)) bus64 ();
   fsgnj_if #(.BUS_WIDTH(32)) bus32 ();

   fsgnj #(.BUS_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
   fsgnj #(.BUS_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [63:0] d;
      string       tag;
   } exp_t;

   exp_t        q64[$];
   exp_t        q32[$];
   logic [63:0] last64;
   logic [31:0] last32;
   int          n_vec;
   int          n_err;

   // Independent reference for the random phase: field extraction by width.
   function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] op);
      logic nan;
      logic s;
      nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      case (op)
         2'b01:   s = ~b[63];
         2'b10:   s = a[63] ^ b[63];
         default: s = b[63];
      endcase
      return nan ? a : {s, a[62:0]};
   endfunction

   task automatic check64();
      exp_t e;
      if (q64.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL q64_empty obs=%h exp=queued_entry", bus64.out);
         return;
      end
      e = q64.pop_front();
      n_vec++;
      assert (bus64.out_valid === e.v) else begin
         n_err++;
         $error("FAIL %s_valid obs=%b exp=%b", e.tag, bus64.out_valid, e.v);
      end
      n_vec++;
      assert (bus64.out === e.d) else begin
         n_err++;
         $error("FAIL %s obs=%h exp=%h", e.tag, bus64.out, e.d);
      end
   endtask

   task automatic check32();
      exp_t e;
      if (q32.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL q32_empty obs=%h exp=queued_entry", bus32.out);
         return;
      end
      e = q32.pop_front();
      n_vec++;
      assert (bus32.out_valid === e.v) else begin
         n_err++;
         $error("FAIL %s_valid obs=%b exp=%b", e.tag, bus32.out_valid, e.v);
      end
      n_vec++;
      assert (bus32.out === e.d[31:0]) else begin
         n_err++;
         $error("FAIL %s obs=%h exp=%h", e.tag, bus32.out, e.d[31:0]);
      end
   endtask

   // Drive one cycle on the 64-bit unit, queue the expectation, check after the edge.
   task automatic step64(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic [63:0] exp_d, input string tag);
      exp_t e;
      bus64.in_valid = v;
      bus64.in1      = a;
      bus64.in2      = b;
`ifdef FSGNJ_EXT_OPS_EN
      bus64.op       = op;
`endif
      if (rst) begin
         last64 = 64'd0;
         e.v    = 1'b0;
      end else begin
         if (v) last64 = exp_d;
         e.v = v;
      end
      e.d   = last64;
      e.tag = tag;
      q64.push_back(e);
      @(posedge clk);
      #1;
      check64();
   endtask

   task automatic step32(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_d, input string tag);
      exp_t e;
      bus32.in_valid = v;
      bus32.in1      = a;
      bus32.in2      = b;
`ifdef FSGNJ_EXT_OPS_EN
      bus32.op       = op;
`endif
      if (rst) begin
         last32 = 32'd0;
         e.v    = 1'b0;
      end else begin
         if (v) last32 = exp_d;
         e.v = v;
      end
      e.d   = {32'd0, last32};
      e.tag = tag;
      q32.push_back(e);
      @(posedge clk);
      #1;
      check32();
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      n_vec  = 0;
      n_err  = 0;
      last64 = 64'd0;
      last32 = 32'd0;
      rst    = 1'b1;
      bus64.in_valid = 1'b0;
      bus64.in1      = 64'd0;
      bus64.in2      = 64'd0;
      bus32.in_valid = 1'b0;
      bus32.in1      = 32'd0;
      bus32.in2      = 32'd0;
`ifdef FSGNJ_EXT_OPS_EN
      bus64.op       = 2'b00;
      bus32.op       = 2'b00;
`endif
      // Reset applied with a valid input present: reset must win.
      step64(1'b1, 64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 64'd0, "reset_prio");
      step64(1'b0, 64'd0, 64'd0, 2'b00, 64'd0, "reset_state");
      rst = 1'b0;

      // First valid after reset release is accepted on that edge; then back-to-back.
      step64(1'b1, 64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 64'hBFF0000000000000, "sgnj_neg");
      step64(1'b1, 64'hBFF0000000000000, 64'h4000000000000000, 2'b00, 64'h3FF0000000000000, "sgnj_pos");
      step64(1'b1, 64'h0000000000000000, 64'h8000000000000000, 2'b00, 64'h8000000000000000, "zero_neg");
      step64(1'b1, 64'h7FF0000000000000, 64'hBFF0000000000000, 2'b00, 64'hFFF0000000000000, "inf_neg");
      step64(1'b1, 64'h123456789ABCDEF0, 64'h7FF8000000000000, 2'b00, 64'h123456789ABCDEF0, "qnan_bypass");
      step64(1'b1, 64'h923456789ABCDEF0, 64'h7FF4000000000000, 2'b00, 64'h923456789ABCDEF0, "snan_bypass");
      step64(1'b1, 64'h4008000000000000, 64'hFFF8000000000000, 2'b00, 64'h4008000000000000, "negnan_bypass");
      step64(1'b1, 64'h7FF0000000000000, 64'h7FF8000000000000, 2'b00, 64'h7FF0000000000000, "inf_nanbypass");
      step64(1'b1, 64'h3FF0000000000000, 64'hFFF0000000000000, 2'b00, 64'hBFF0000000000000, "in2_inf_not_nan");
      step64(1'b1, 64'hFFF8000000000000, 64'h3FF0000000000000, 2'b00, 64'h7FF8000000000000, "in1_nan");
      step64(1'b1, 64'h0008000000000000, 64'hBFF0000000000000, 2'b00, 64'h8008000000000000, "in1_denorm");
      step64(1'b1, 64'h7FEFFFFFFFFFFFFF, 64'h8000000000000000, 2'b00, 64'hFFEFFFFFFFFFFFFF, "in1_maxnorm");
      step64(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h7FF0000000000001, 2'b00, 64'hFFFFFFFFFFFFFFFF, "nan_minfrac");

      // Idle cycles hold the last result with out_valid low.
      step64(1'b0, 64'h1111111111111111, 64'h8000000000000000, 2'b00, 64'd0, "idle_hold1");
      step64(1'b0, 64'h2222222222222222, 64'h0000000000000000, 2'b00, 64'd0, "idle_hold2");
      step64(1'b1, 64'hC000000000000000, 64'h0000000000000000, 2'b00, 64'h4000000000000000, "after_idle");

`ifdef FSGNJ_EXT_OPS_EN
      step64(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b01, 64'hBFF0000000000000, "sgnjn");
      step64(1'b1, 64'hBFF0000000000000, 64'hC000000000000000, 2'b10, 64'h3FF0000000000000, "sgnjx");
      step64(1'b1, 64'h3FF0000000000000, 64'hC000000000000000, 2'b11, 64'hBFF0000000000000, "op11_sgnj");
      step64(1'b1, 64'h3FF0000000000000, 64'h7FF8000000000000, 2'b01, 64'h3FF0000000000000, "sgnjn_nanprio");
`endif

      // Random vectors against the reference model; half of in2 forced to exp all-ones.
      for (int i = 0; i < 12; i++) begin
         logic [1:0] op;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i[0]) rb[62:52] = 11'h7FF;
         if (i == 5) rb[51:0] = 52'd0;
`ifdef FSGNJ_EXT_OPS_EN
         op = 2'($urandom_range(0, 3));
`else
         op = 2'b00;
`endif
         step64(1'b1, ra, rb, op, ref64(ra, rb, op), "random");
      end

      // Reset mid-stream clears the result register.
      rst = 1'b1;
      step64(1'b1, 64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 64'd0, "mid_reset");
      rst = 1'b0;
      step64(1'b0, 64'd0, 64'd0, 2'b00, 64'd0, "post_reset_idle");

      // binary32 instance.
      step32(1'b1, 32'h3F800000, 32'hC0000000, 2'b00, 32'hBF800000, "sp_sgnj");
      step32(1'b1, 32'h40490FDB, 32'h7FC00000, 2'b00, 32'h40490FDB, "sp_nan_bypass");
      step32(1'b1, 32'hC0490FDB, 32'h7F800000, 2'b00, 32'h40490FDB, "sp_inf_not_nan");
      step32(1'b1, 32'h3F800000, 32'hFF800001, 2'b00, 32'h3F800000, "sp_snan_bypass");
      step32(1'b0, 32'h00000000, 32'h80000000, 2'b00, 32'd0, "sp_idle_hold");
`ifdef FSGNJ_EXT_OPS_EN
      step32(1'b1, 32'h3F800000, 32'h3F800000, 2'b01, 32'hBF800000, "sp_sgnjn");
      step32(1'b1, 32'hBF800000, 32'h80000000, 2'b10, 32'h3F800000, "sp_sgnjx");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "bench time limit reached");
   end
endmodule
